// File: rtl/repair_arbiter.sv
// Miss-repair arbiter: round-robin grant of refill/writeback requests from
// NUM_CH cache controllers onto one line-wide memory port, one transaction at a time.
module repair_arbiter #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 32,
   parameter int LINE_BITS   = 1024,
   parameter int WRITE_FIRST = 1,
   parameter int MASK_W      = LINE_BITS / 8,
   parameter int OFS_W       = $clog2(LINE_BITS / 8)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           rd_repair_req,
   input  logic [NUM_CH-1:0]           wr_repair_req,
   input  logic [NUM_CH*ADDR_W-1:0]    missed_addr,
   input  logic [NUM_CH*LINE_BITS-1:0] ch_wdata,
   input  logic [NUM_CH*MASK_W-1:0]    ch_wmask,
   output logic [NUM_CH-1:0]           rd_repair_acq,
   output logic [NUM_CH-1:0]           wr_repair_acq,
   output logic [NUM_CH-1:0]           repair_resolved,
   output logic [LINE_BITS-1:0]        resp_rdata,
   output logic                        mem_raddr_valid,
   output logic [ADDR_W-1:0]           mem_raddr,
   output logic                        mem_waddr_valid,
   output logic [ADDR_W-1:0]           mem_waddr,
   output logic [LINE_BITS-1:0]        mem_wdata,
   output logic [MASK_W-1:0]           mem_wmask,
   input  logic                        mem_req_ready,
   input  logic                        mem_rdata_valid,
   input  logic [LINE_BITS-1:0]        mem_rdata,
   input  logic                        mem_wdone,
   output logic                        busy
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic                  op_wr_q, op_wr_d;
   logic [NUM_CH-1:0]     rd_acq_q, rd_acq_d;
   logic [NUM_CH-1:0]     wr_acq_q, wr_acq_d;
   logic [NUM_CH-1:0]     resolved_q, resolved_d;
   logic [LINE_BITS-1:0]  resp_rdata_q, resp_rdata_d;
   logic                  raddr_valid_q, raddr_valid_d;
   logic [ADDR_W-1:0]     raddr_q, raddr_d;
   logic                  waddr_valid_q, waddr_valid_d;
   logic [ADDR_W-1:0]     waddr_q, waddr_d;
   logic [LINE_BITS-1:0]  wdata_q, wdata_d;
   logic [MASK_W-1:0]     wmask_q, wmask_d;

   logic [NUM_CH-1:0]     cand;
   logic                  found;
   int                    win_i;
   logic                  done;

   // Candidate set and first candidate at or after rr_ptr, wrapping.
   always_comb begin
      cand  = ((WRITE_FIRST != 0) && (|wr_repair_req)) ? wr_repair_req
                                                       : (rd_repair_req | wr_repair_req);
      found = 1'b0;
      win_i = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         int idx;
         idx = (int'(rr_ptr_q) + i) % NUM_CH;
         if (!found && cand[idx]) begin
            found = 1'b1;
            win_i = idx;
         end
      end
   end

   assign done = op_wr_q ? mem_wdone : mem_rdata_valid;

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      ch_d          = ch_q;
      op_wr_d       = op_wr_q;
      rd_acq_d      = '0;
      wr_acq_d      = '0;
      resolved_d    = '0;
      resp_rdata_d  = resp_rdata_q;
      raddr_valid_d = raddr_valid_q;
      raddr_d       = raddr_q;
      waddr_valid_d = waddr_valid_q;
      waddr_d       = waddr_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               ch_d    = CH_W'(win_i);
               op_wr_d = wr_repair_req[win_i];
               state_d = ISSUE;
               // A channel with both requests pending goes writeback first.
               if (wr_repair_req[win_i]) begin
                  wr_acq_d      = NUM_CH'(1) << win_i;
                  waddr_valid_d = 1'b1;
                  waddr_d       = missed_addr[win_i*ADDR_W +: ADDR_W] & LINE_MASK;
                  wdata_d       = ch_wdata[win_i*LINE_BITS +: LINE_BITS];
                  wmask_d       = ch_wmask[win_i*MASK_W +: MASK_W];
               end else begin
                  rd_acq_d      = NUM_CH'(1) << win_i;
                  raddr_valid_d = 1'b1;
                  raddr_d       = missed_addr[win_i*ADDR_W +: ADDR_W] & LINE_MASK;
               end
            end
         end
         ISSUE: begin
            if (mem_req_ready) begin
               raddr_valid_d = 1'b0;
               waddr_valid_d = 1'b0;
               state_d       = WAIT;
            end
         end
         WAIT: begin
            if (done) begin
               resolved_d = NUM_CH'(1) << ch_q;
               if (!op_wr_q) resp_rdata_d = mem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            rr_ptr_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         ch_q          <= '0;
         op_wr_q       <= 1'b0;
         rd_acq_q      <= '0;
         wr_acq_q      <= '0;
         resolved_q    <= '0;
         resp_rdata_q  <= '0;
         raddr_valid_q <= 1'b0;
         raddr_q       <= '0;
         waddr_valid_q <= 1'b0;
         waddr_q       <= '0;
         wdata_q       <= '0;
         wmask_q       <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         ch_q          <= ch_d;
         op_wr_q       <= op_wr_d;
         rd_acq_q      <= rd_acq_d;
         wr_acq_q      <= wr_acq_d;
         resolved_q    <= resolved_d;
         resp_rdata_q  <= resp_rdata_d;
         raddr_valid_q <= raddr_valid_d;
         raddr_q       <= raddr_d;
         waddr_valid_q <= waddr_valid_d;
         waddr_q       <= waddr_d;
         wdata_q       <= wdata_d;
         wmask_q       <= wmask_d;
      end
   end

   assign rd_repair_acq   = rd_acq_q;
   assign wr_repair_acq   = wr_acq_q;
   assign repair_resolved = resolved_q;
   assign resp_rdata      = resp_rdata_q;
   assign mem_raddr_valid = raddr_valid_q;
   assign mem_raddr       = raddr_q;
   assign mem_waddr_valid = waddr_valid_q;
   assign mem_waddr       = waddr_q;
   assign mem_wdata       = wdata_q;
   assign mem_wmask       = wmask_q;
   assign busy            = (state_q != IDLE);

endmodule
